// File: rtl/sync_pkg.sv
// Shared helpers for the synchroniser/filter bank: width calculation and
// parameter legality checks used at elaboration time.
package sync_pkg;

    localparam int MIN_SYNC_STAGES   = 2;
    localparam int MIN_FILTER_CYCLES = 1;
    localparam int MIN_CHANNELS      = 1;

    // Registered strobe pair for one channel; never both set at once.
    typedef struct packed {
        logic rise;
        logic fall;
    } strobe_t;

    // Ceiling log2 with a floor of 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        for (int w = 1; w < 31; w++) begin
            if ((1 << w) >= value) return w;
        end
        return 31;
    endfunction

    function automatic bit params_ok(input int sync_stages, input int filter_cycles);
        return (sync_stages >= MIN_SYNC_STAGES) && (filter_cycles >= MIN_FILTER_CYCLES);
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: multi-flop synchroniser followed by a stability filter that
// accepts a new level only after it has persisted for FILTER_CYCLES cycles.
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int                CNT_W   = clog2(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    if (!params_ok(SYNC_STAGES, FILTER_CYCLES)) begin : g_param_check
        $error("sync_filter_ch: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
    end

    // Stage 0 samples the raw pin directly; keep the chain packed together.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    strobe_t          strobe_q, strobe_d;
    logic             s;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes this a chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= {SYNC_STAGES{RESET_VAL}};
            level_q  <= RESET_VAL;
            cnt_q    <= '0;
            strobe_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        level_d  = level_q;
        cnt_d    = cnt_q;
        strobe_d = '0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d       = s;
            cnt_d         = '0;
            strobe_d.rise = s;
            strobe_d.fall = ~s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign level_o = level_q;
    assign rise_o  = strobe_q.rise;
    assign fall_o  = strobe_q.fall;

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of independent synchronise-and-debounce channels for asynchronous
// level inputs, with per-channel filtered level and rise/fall strobes.
module sync_filter_bank
    import sync_pkg::*;
#(
    parameter int                  CHANNELS      = 4,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  FILTER_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
    input  logic                dest_clk,
    input  logic                dest_rst,
    input  logic [CHANNELS-1:0] src_in,
    output logic [CHANNELS-1:0] dest_out,
    output logic [CHANNELS-1:0] dest_rise,
    output logic [CHANNELS-1:0] dest_fall
);

    if (CHANNELS < MIN_CHANNELS) begin : g_channel_check
        $error("sync_filter_bank: CHANNELS must be >= 1");
    end

    // Channels share only clock and reset; there is no cross-channel coherency.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_filter_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .RESET_VAL    (RESET_VAL[i])
        ) u_ch (
            .clk_i  (dest_clk),
            .rst_i  (dest_rst),
            .async_i(src_in[i]),
            .level_o(dest_out[i]),
            .rise_o (dest_rise[i]),
            .fall_o (dest_fall[i])
        );
    end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Self-checking bench: default instance plus a swept-parameter instance, both
// checked every cycle against a window-based behavioural model.
module tb_sync_filter_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] src = 4'hF;

    logic [3:0] a_out, a_rise, a_fall;
    logic [3:0] b_out, b_rise, b_fall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_filter_bank #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(4'h0)
    ) u_dut_a (
        .dest_clk(clk), .dest_rst(rst), .src_in(src),
        .dest_out(a_out), .dest_rise(a_rise), .dest_fall(a_fall)
    );

    sync_filter_bank #(
        .CHANNELS(4), .SYNC_STAGES(3), .FILTER_CYCLES(1), .RESET_VAL(4'hA)
    ) u_dut_b (
        .dest_clk(clk), .dest_rst(rst), .src_in(src),
        .dest_out(b_out), .dest_rise(b_rise), .dest_fall(b_fall)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: s is the input delayed by SYNC_STAGES edges; the level flips once
    // the last FILTER_CYCLES values of s all disagree with the current level.
    int         m_stages[2] = '{2, 3};
    int         m_filt[2]   = '{4, 1};
    logic [3:0] m_rv[2]     = '{4'h0, 4'hA};
    logic [3:0] line_q[2][$];
    logic [3:0] win_q[2][$];
    logic [3:0] m_out[2];
    logic [3:0] m_rise[2];
    logic [3:0] m_fall[2];
    bit         m_init = 1'b0;

    task automatic model_step(input int k);
        logic [3:0] s;
        logic [3:0] flip;
        bit         all_diff;
        if (rst) begin
            line_q[k].delete();
            for (int i = 0; i < m_stages[k]; i++) line_q[k].push_front(m_rv[k]);
            win_q[k].delete();
            m_out[k]  = m_rv[k];
            m_rise[k] = 4'h0;
            m_fall[k] = 4'h0;
        end else if (m_init) begin
            s = line_q[k].pop_back();
            line_q[k].push_front(src);
            win_q[k].push_back(s);
            if (win_q[k].size() > m_filt[k]) void'(win_q[k].pop_front());
            flip = 4'h0;
            if (win_q[k].size() == m_filt[k]) begin
                for (int ch = 0; ch < 4; ch++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < win_q[k].size(); j++)
                        if (win_q[k][j][ch] == m_out[k][ch]) all_diff = 1'b0;
                    flip[ch] = all_diff;
                end
            end
            m_out[k]  = m_out[k] ^ flip;
            m_rise[k] = flip & m_out[k];
            m_fall[k] = flip & ~m_out[k];
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        if (rst) m_init = 1'b1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("a_out",  a_out,  m_out[0]);
            check("a_rise", a_rise, m_rise[0]);
            check("a_fall", a_fall, m_fall[0]);
            check("b_out",  b_out,  m_out[1]);
            check("b_rise", b_rise, m_rise[1]);
            check("b_fall", b_fall, m_fall[1]);
        end
    end

    task automatic step_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [3:0] seen;
    int         toggle_div;

    initial begin
        // Reset held 3 cycles with all inputs high.
        for (int i = 0; i < 3; i++) begin
            step_edges(1);
            check("rst_out",  a_out,  4'h0);
            check("rst_rise", a_rise, 4'h0);
            check("rst_bout", b_out,  4'hA);
        end
        rst = 1'b0;
        step_edges(3);
        check("b_edge3_out", b_out, 4'hA);
        step_edges(1);
        check("b_edge4_out",  b_out,  4'hF);
        check("b_edge4_rise", b_rise, 4'h5);
        check("a_edge4_out",  a_out,  4'h0);
        step_edges(1);
        check("a_edge5_out", a_out, 4'h0);
        step_edges(1);
        check("a_edge6_out",  a_out,  4'hF);
        check("a_edge6_rise", a_rise, 4'hF);
        step_edges(1);
        check("a_edge7_rise", a_rise, 4'h0);
        check("a_edge7_out",  a_out,  4'hF);

        src = 4'h0; rst = 1'b1;
        step_edges(1);
        rst = 1'b0;
        check("rst2_out", a_out, 4'h0);
        step_edges(8);

        // Clean edge on channel 0.
        src = 4'h1;
        step_edges(5);
        check("clean_e5_out", a_out, 4'h0);
        step_edges(1);
        check("clean_e6_out",  a_out,  4'h1);
        check("clean_e6_rise", a_rise, 4'h1);
        step_edges(1);
        check("clean_e7_rise", a_rise, 4'h0);
        src = 4'h0;
        step_edges(6);
        check("clean_fall", a_fall, 4'h1);
        check("clean_fall_out", a_out, 4'h0);
        step_edges(4);

        // 3-cycle glitches on channel 1 are rejected.
        seen = 4'h0;
        for (int p = 0; p < 3; p++) begin
            src = 4'h2;
            for (int i = 0; i < 3; i++) begin step_edges(1); seen |= a_rise | a_fall; end
            src = 4'h0;
            for (int i = 0; i < 7; i++) begin step_edges(1); seen |= a_rise | a_fall; end
        end
        check("glitch_strobe", seen, 4'h0);
        check("glitch_out", a_out, 4'h0);

        // 4-cycle pulse is accepted.
        src = 4'h2;
        step_edges(4);
        src = 4'h0;
        step_edges(2);
        check("pulse4_out",  a_out,  4'h2);
        check("pulse4_rise", a_rise, 4'h2);
        step_edges(10);
        check("pulse4_back", a_out, 4'h0);

        // Independence: channels 2,3 together, channel 0 two cycles later.
        src = 4'hC;
        step_edges(2);
        src = 4'hD;
        step_edges(4);
        check("indep_rise23", a_rise, 4'hC);
        check("indep_out23",  a_out,  4'hC);
        step_edges(2);
        check("indep_rise0", a_rise, 4'h1);
        check("indep_out0",  a_out,  4'hD);
        src = 4'h0;
        step_edges(10);

        // Reset at edge 5 cancels a pending acceptance on channel 2.
        src = 4'h4;
        step_edges(4);
        rst = 1'b1;
        step_edges(1);
        rst = 1'b0;
        check("midrst_out",  a_out,  4'h0);
        check("midrst_rise", a_rise, 4'h0);
        step_edges(5);
        check("midrst_e5_out", a_out, 4'h0);
        step_edges(1);
        check("midrst_e6_out",  a_out,  4'h4);
        check("midrst_e6_rise", a_rise, 4'h4);
        src = 4'h0;
        step_edges(10);

        // Randomised phase alternating noisy and calm input activity.
        for (int c = 0; c < 3000; c++) begin
            toggle_div = ((c / 200) % 2 == 0) ? 3 : 12;
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(toggle_div - 1) == 0) src[ch] = ~src[ch];
            rst = ($urandom_range(399) == 0);
            step_edges(1);
        end
        rst = 1'b0;
        step_edges(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
